// File: rtl/mbist_data_cmp_if.sv
// mbist_data_cmp_if: compare request, read data, scan and result signals of the MBIST data checker
interface mbist_data_cmp_if #(
  parameter int ADDR_WD    = 9,
  parameter int DATA_WD    = 32,
  parameter int ERR_CNT_WD = 4
) ();
  logic                  cmp_en;
  logic [ADDR_WD-1:0]    cmp_addr;
  logic [DATA_WD-1:0]    pat_data;
  logic                  cmp_inv;
  logic [DATA_WD-1:0]    mem_rdata;
  logic                  clear;
  logic                  scan_shift;
  logic                  sdi;
  logic                  sdo;
  logic                  err_valid;
  logic                  err_sticky;
  logic [ADDR_WD-1:0]    err_addr;
  logic [DATA_WD-1:0]    err_bmap;
  logic [ERR_CNT_WD-1:0] err_cnt;
  logic                  err_ovf;
  modport master (
    output cmp_en, cmp_addr, pat_data, cmp_inv, mem_rdata, clear, scan_shift, sdi,
    input  sdo, err_valid, err_sticky, err_addr, err_bmap, err_cnt, err_ovf
  );
  modport slave (
    input  cmp_en, cmp_addr, pat_data, cmp_inv, mem_rdata, clear, scan_shift, sdi,
    output sdo, err_valid, err_sticky, err_addr, err_bmap, err_cnt, err_ovf
  );
endinterface

// File: rtl/mbist_data_cmp.sv
// mbist_data_cmp: latency-matched read-data compare with fail capture and scan readout
module mbist_data_cmp #(
  parameter int BIST_ADDR_WD    = 9,
  parameter int BIST_DATA_WD    = 32,
  parameter int BIST_RD_LAT     = 1,
  parameter int BIST_ERR_CNT_WD = 4
) (
  input logic           clk,
  input logic           rst_n,
  mbist_data_cmp_if.slave bus
);
  localparam int L = BIST_RD_LAT;
  logic [L-1:0]                 vld;
  logic [BIST_ADDR_WD-1:0]      addr_q [L];
  logic [BIST_DATA_WD-1:0]      exp_q  [L];
  logic [BIST_DATA_WD-1:0]      mism;
  logic                         fail;
  logic                         kill;
  logic                         valid_q;
  logic                         sticky_q;
  logic                         ovf_q;
  logic [BIST_ERR_CNT_WD-1:0]   cnt_q;
  logic [BIST_ADDR_WD-1:0]      eaddr_q;
  logic [BIST_DATA_WD-1:0]      bmap_q;

  // compare the oldest pipeline stage against the returning read data
  always_comb begin
    kill = bus.clear | bus.scan_shift;
    mism = bus.mem_rdata ^ exp_q[L-1];
    fail = vld[L-1] & (|mism);
  end

  // delay line carrying valid/address/expected word to match read latency
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      vld <= '0;
      for (int i = 0; i < L; i++) begin
        addr_q[i] <= '0;
        exp_q[i]  <= '0;
      end
    end else begin
      vld[0]    <= bus.cmp_en & ~kill;
      addr_q[0] <= bus.cmp_addr;
      exp_q[0]  <= bus.pat_data ^ {BIST_DATA_WD{bus.cmp_inv}};
      for (int i = 1; i < L; i++) begin
        vld[i]    <= vld[i-1] & ~kill;
        addr_q[i] <= addr_q[i-1];
        exp_q[i]  <= exp_q[i-1];
      end
    end
  end

  // result registers: clear wins over scan shift, which wins over capturing a fail
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      {ovf_q, sticky_q, cnt_q, eaddr_q, bmap_q} <= '0;
      valid_q <= 1'b0;
    end else if (bus.clear) begin
      {ovf_q, sticky_q, cnt_q, eaddr_q, bmap_q} <= '0;
      valid_q <= 1'b0;
    end else if (bus.scan_shift) begin
      {ovf_q, sticky_q, cnt_q, eaddr_q, bmap_q} <=
        {bus.sdi, ovf_q, sticky_q, cnt_q, eaddr_q, bmap_q[BIST_DATA_WD-1:1]};
      valid_q <= 1'b0;
    end else begin
      valid_q <= fail;
      if (fail) begin
        bmap_q   <= bmap_q | mism;
        sticky_q <= 1'b1;
        if (!sticky_q) eaddr_q <= addr_q[L-1];
        if (&cnt_q) ovf_q <= 1'b1;
        else cnt_q <= cnt_q + 1'b1;
      end
    end
  end

  assign bus.sdo        = bmap_q[0];
  assign bus.err_valid  = valid_q;
  assign bus.err_sticky = sticky_q;
  assign bus.err_addr   = eaddr_q;
  assign bus.err_bmap   = bmap_q;
  assign bus.err_cnt    = cnt_q;
  assign bus.err_ovf    = ovf_q;
endmodule

// File: tb/tb_mbist_data_cmp.sv
// tb_mbist_data_cmp: directed checks of the MBIST data comparator at read latency 1 and 2
module tb_mbist_data_cmp;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  int   n_tests = 0;
  int   n_fail = 0;
  logic [46:0] chain_exp;
  logic [46:0] chain_got;

  always #5 clk = ~clk;

  mbist_data_cmp_if b1 ();
  mbist_data_cmp_if b2 ();

  mbist_data_cmp #(.BIST_RD_LAT(1)) u_lat1 (.clk(clk), .rst_n(rst_n), .bus(b1));
  mbist_data_cmp #(.BIST_RD_LAT(2)) u_lat2 (.clk(clk), .rst_n(rst_n), .bus(b2));

  task automatic cyc();
    @(negedge clk);
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic clr2();
    b2.clear = 1'b1;
    cyc();
    b2.clear = 1'b0;
  endtask

  task automatic issue2(input logic [8:0] a, input logic [31:0] p, input logic inv);
    b2.cmp_en = 1'b1;
    b2.cmp_addr = a;
    b2.pat_data = p;
    b2.cmp_inv = inv;
  endtask

  initial begin
    {b1.cmp_en, b1.cmp_addr, b1.pat_data, b1.cmp_inv, b1.mem_rdata, b1.clear, b1.scan_shift, b1.sdi} = '0;
    {b2.cmp_en, b2.cmp_addr, b2.pat_data, b2.cmp_inv, b2.mem_rdata, b2.clear, b2.scan_shift, b2.sdi} = '0;
    cyc();
    cyc();
    chk("rst_valid", b2.err_valid, 0);
    chk("rst_sticky", b2.err_sticky, 0);
    chk("rst_addr", b2.err_addr, 0);
    chk("rst_bmap", b2.err_bmap, 0);
    chk("rst_cnt", b2.err_cnt, 0);
    chk("rst_ovf", b2.err_ovf, 0);
    chk("rst_sdo", b2.sdo, 0);
    rst_n = 1'b1;
    cyc();
    // latency 1: matching read passes
    b1.cmp_en = 1'b1; b1.cmp_addr = 9'h010; b1.pat_data = 32'hAAAA5555;
    cyc();
    b1.cmp_en = 1'b0; b1.mem_rdata = 32'hAAAA5555;
    cyc();
    chk("l1_pass_valid", b1.err_valid, 0);
    cyc();
    chk("l1_pass_sticky", b1.err_sticky, 0);
    chk("l1_pass_cnt", b1.err_cnt, 0);
    // latency 1: mismatch flagged exactly two cycles after issue
    b1.cmp_en = 1'b1; b1.cmp_addr = 9'h011; b1.pat_data = 32'h0;
    cyc();
    b1.cmp_en = 1'b0; b1.mem_rdata = 32'h10;
    chk("l1_early_valid", b1.err_valid, 0);
    cyc();
    b1.mem_rdata = 32'h0;
    chk("l1_fail_valid", b1.err_valid, 1);
    chk("l1_fail_addr", b1.err_addr, 9'h011);
    chk("l1_fail_bmap", b1.err_bmap, 32'h10);
    cyc();
    chk("l1_valid_pulse", b1.err_valid, 0);
    // latency 2: two back-to-back failures
    issue2(9'h020, 32'h12345678, 1'b0);
    cyc();
    issue2(9'h030, 32'h00000000, 1'b0);
    cyc();
    b2.cmp_en = 1'b0; b2.mem_rdata = 32'h12345679;
    chk("l2_early_valid", b2.err_valid, 0);
    cyc();
    b2.mem_rdata = 32'h80000000;
    chk("l2_fail1_valid", b2.err_valid, 1);
    cyc();
    b2.mem_rdata = 32'h0;
    chk("l2_fail2_valid", b2.err_valid, 1);
    cyc();
    chk("l2_valid_end", b2.err_valid, 0);
    chk("l2_addr_first", b2.err_addr, 9'h020);
    chk("l2_bmap", b2.err_bmap, 32'h80000001);
    chk("l2_cnt", b2.err_cnt, 2);
    chk("l2_sticky", b2.err_sticky, 1);
    chk("l2_ovf", b2.err_ovf, 0);
    // clear wipes results
    clr2();
    chk("clr_sticky", b2.err_sticky, 0);
    chk("clr_bmap", b2.err_bmap, 0);
    chk("clr_cnt", b2.err_cnt, 0);
    // inverted expectation: first read passes, second fails on every bit
    issue2(9'h040, 32'hFFFF0000, 1'b1);
    cyc();
    issue2(9'h041, 32'hFFFF0000, 1'b1);
    cyc();
    b2.cmp_en = 1'b0; b2.cmp_inv = 1'b0; b2.mem_rdata = 32'h0000FFFF;
    cyc();
    b2.mem_rdata = 32'hFFFF0000;
    chk("inv_pass_valid", b2.err_valid, 0);
    cyc();
    b2.mem_rdata = 32'h0;
    chk("inv_fail_valid", b2.err_valid, 1);
    cyc();
    chk("inv_bmap", b2.err_bmap, 32'hFFFFFFFF);
    chk("inv_addr", b2.err_addr, 9'h041);
    chk("inv_cnt", b2.err_cnt, 1);
    // counter saturation and overflow
    clr2();
    b2.mem_rdata = 32'h1;
    for (int i = 0; i < 15; i++) begin
      issue2(9'(i), 32'h0, 1'b0);
      cyc();
    end
    b2.cmp_en = 1'b0;
    cyc();
    cyc();
    chk("sat15_cnt", b2.err_cnt, 4'hF);
    chk("sat15_ovf", b2.err_ovf, 0);
    issue2(9'd15, 32'h0, 1'b0);
    cyc();
    b2.cmp_en = 1'b0;
    cyc();
    cyc();
    chk("sat16_valid", b2.err_valid, 1);
    chk("sat16_cnt", b2.err_cnt, 4'hF);
    chk("sat16_ovf", b2.err_ovf, 1);
    issue2(9'd16, 32'h0, 1'b0);
    cyc();
    b2.cmp_en = 1'b0;
    cyc();
    cyc();
    chk("sat17_valid", b2.err_valid, 1);
    chk("sat17_cnt", b2.err_cnt, 4'hF);
    chk("sat17_ovf", b2.err_ovf, 1);
    chk("sat17_addr", b2.err_addr, 9'h000);
    // clear in the cycle a failure resolves discards it
    clr2();
    issue2(9'h050, 32'h0, 1'b0);
    cyc();
    b2.cmp_en = 1'b0;
    cyc();
    b2.clear = 1'b1;
    cyc();
    b2.clear = 1'b0;
    chk("clrres_valid", b2.err_valid, 0);
    chk("clrres_sticky", b2.err_sticky, 0);
    chk("clrres_cnt", b2.err_cnt, 0);
    chk("clrres_bmap", b2.err_bmap, 0);
    issue2(9'h060, 32'h0, 1'b0);
    cyc();
    b2.cmp_en = 1'b0;
    cyc();
    cyc();
    chk("afterclr_valid", b2.err_valid, 1);
    chk("afterclr_addr", b2.err_addr, 9'h060);
    chk("afterclr_cnt", b2.err_cnt, 1);
    // scan shift in the resolve cycle suppresses the compare
    clr2();
    issue2(9'h070, 32'h0, 1'b0);
    cyc();
    b2.cmp_en = 1'b0;
    cyc();
    b2.scan_shift = 1'b1;
    cyc();
    b2.scan_shift = 1'b0;
    chk("scansup_valid", b2.err_valid, 0);
    chk("scansup_sticky", b2.err_sticky, 0);
    // scan readout of a single failure
    issue2(9'h1F8, 32'h0, 1'b0);
    cyc();
    b2.cmp_en = 1'b0; b2.mem_rdata = 32'h0;
    cyc();
    b2.mem_rdata = 32'h4;
    cyc();
    b2.mem_rdata = 32'h0;
    chk("scanfail_valid", b2.err_valid, 1);
    cyc();
    chk("scanfail_addr", b2.err_addr, 9'h1F8);
    chain_exp = {1'b0, 1'b1, 4'd1, 9'h1F8, 32'h00000004};
    b2.scan_shift = 1'b1; b2.sdi = 1'b0;
    for (int k = 0; k < 47; k++) begin
      chain_got[k] = b2.sdo;
      cyc();
    end
    b2.scan_shift = 1'b0;
    chk("scan_stream", chain_got, chain_exp);
    chk("scan_empty_sticky", b2.err_sticky, 0);
    chk("scan_empty_addr", b2.err_addr, 0);
    chk("scan_empty_bmap", b2.err_bmap, 0);
    chk("scan_empty_cnt", b2.err_cnt, 0);
    chk("scan_empty_ovf", b2.err_ovf, 0);
    // asynchronous reset mid-operation
    b2.mem_rdata = 32'h1;
    issue2(9'h0AA, 32'h0, 1'b0);
    cyc();
    b2.cmp_en = 1'b0;
    cyc();
    cyc();
    chk("prerst_sticky", b2.err_sticky, 1);
    #1 rst_n = 1'b0;
    #1;
    chk("arst_sticky", b2.err_sticky, 0);
    chk("arst_cnt", b2.err_cnt, 0);
    chk("arst_valid", b2.err_valid, 0);
    cyc();
    rst_n = 1'b1;
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
